// File: rtl/fp_round_pack.sv
// Normalize, round and pack back end of the binary64 add/sub datapath (3-stage valid/ready pipe).
// Define FPU_ROUND_FTZ_EN to flush results that are denormal after rounding to signed zero.
module fp_round_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] es,
  input  logic [56:0] fs,
  input  logic        ss,
  input  logic        zero,
  input  logic        inv,
  input  logic        infs,
  input  logic        nans,
  input  logic [52:0] nan,
  input  logic [1:0]  RM,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        fl_ovf,
  output logic        fl_unf,
  output logic        fl_inx,
  output logic        fl_inv
);

  // Handshake: a beat moves on a rising edge when valid & ready are both high;
  // a stage loads when it is empty or its own beat leaves in the same cycle.
  logic v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
  logic ld1, ld2, ld3;

  logic [55:0] s1_m_q, s1_m_d;
  logic [12:0] s1_e_q, s1_e_d;
  logic        s1_ss_q, s1_ss_d;
  logic [1:0]  s1_rm_q, s1_rm_d;
  logic [3:0]  s1_spc_q, s1_spc_d;
  logic [50:0] s1_nan_q, s1_nan_d;

  logic [63:0] s2_res_q, s2_res_d;
  logic [2:0]  s2_flg_q, s2_flg_d;
  logic        s2_ss_q, s2_ss_d;
  logic [3:0]  s2_spc_q, s2_spc_d;
  logic [50:0] s2_nan_q, s2_nan_d;

  logic [63:0] s3_res_q, s3_res_d;
  logic [3:0]  s3_flg_q, s3_flg_d;

  logic unused_nan_hi;
  assign unused_nan_hi = ^nan[52:51];

  always_comb begin
    ld3      = v2_q & (~v3_q | out_ready);
    ld2      = v1_q & (~v2_q | ld3);
    in_ready = ~v1_q | ld2;
    ld1      = in_valid & in_ready;
    v1_d     = ld1 | (v1_q & ~ld2);
    v2_d     = ld2 | (v2_q & ~ld3);
    v3_d     = ld3 | (v3_q & ~out_ready);
  end

  // Stage 1: normalize. Left shift is capped so the exponent never drops below 1.
  logic [12:0] e_in, lz, shamt, n1_e;
  logic [55:0] n1_m;

  always_comb begin
    e_in  = (es == 11'd0) ? 13'd1 : {2'b00, es};
    lz    = 13'd56;
    for (int i = 0; i < 56; i++) begin
      if (fs[i]) lz = 13'(55 - i);
    end
    shamt = 13'd0;
    n1_m  = fs[55:0];
    n1_e  = e_in;
    if (fs[56]) begin
      n1_m = {fs[56:2], fs[1] | fs[0]};
      n1_e = e_in + 13'd1;
    end else if (fs[55:0] != 56'd0) begin
      shamt = (lz < e_in - 13'd1) ? lz : e_in - 13'd1;
      n1_m  = fs[55:0] << shamt;
      n1_e  = e_in - shamt;
    end
  end

  // Stage 2: round, detect overflow, assemble the finite/overflow encoding.
  logic        rnd_x, rnd_inc, rnd_ovf, rnd_inf, rnd_unf, rnd_inx;
  logic [53:0] rnd_sum;
  logic [52:0] rnd_sig;
  logic [12:0] rnd_e;
  logic [63:0] rnd_res;

  always_comb begin
    rnd_x = |s1_m_q[2:0];
    case (s1_rm_q)
      2'b00:   rnd_inc = s1_m_q[2] & (s1_m_q[1] | s1_m_q[0] | s1_m_q[3]);
      2'b01:   rnd_inc = 1'b0;
      2'b10:   rnd_inc = ~s1_ss_q & rnd_x;
      default: rnd_inc = s1_ss_q & rnd_x;
    endcase
    rnd_sum = {1'b0, s1_m_q[55:3]} + {53'd0, rnd_inc};
    rnd_sig = rnd_sum[52:0];
    rnd_e   = s1_e_q;
    if (rnd_sum[53]) begin
      rnd_sig = {1'b1, 52'd0};
      rnd_e   = s1_e_q + 13'd1;
    end
    rnd_ovf = (rnd_e >= 13'd2047);
    rnd_inf = (s1_rm_q == 2'b00) | ((s1_rm_q == 2'b10) & ~s1_ss_q) |
              ((s1_rm_q == 2'b11) & s1_ss_q);
    rnd_inx = rnd_x | rnd_ovf;
    rnd_unf = ~s1_m_q[55] & rnd_x;
    if (rnd_ovf) begin
      rnd_res = rnd_inf ? {s1_ss_q, 11'h7ff, 52'd0} : {s1_ss_q, 11'h7fe, {52{1'b1}}};
    end else begin
      rnd_res = {s1_ss_q, rnd_sig[52] ? rnd_e[10:0] : 11'd0, rnd_sig[51:0]};
    end
`ifdef FPU_ROUND_FTZ_EN
    if (!rnd_ovf && !rnd_sig[52] && (rnd_sig[51:0] != 52'd0)) begin
      rnd_res = {s1_ss_q, 63'd0};
      rnd_unf = 1'b1;
      rnd_inx = 1'b1;
    end
`endif
  end

  // Stage 3: special operands override the rounded value and clear its flags.
  logic [63:0] pk_res;
  logic [3:0]  pk_flg;

  always_comb begin
    pk_res = s2_res_q;
    pk_flg = {s2_flg_q, 1'b0};
    if (s2_spc_q[3]) begin
      pk_res = {1'b0, 11'h7ff, 1'b1, s2_nan_q};
      pk_flg = 4'b0000;
    end else if (s2_spc_q[2]) begin
      pk_res = 64'h7ff8_0000_0000_0000;
      pk_flg = 4'b0001;
    end else if (s2_spc_q[1]) begin
      pk_res = {s2_ss_q, 11'h7ff, 52'd0};
      pk_flg = 4'b0000;
    end else if (s2_spc_q[0]) begin
      pk_res = {s2_ss_q, 63'd0};
      pk_flg = 4'b0000;
    end
  end

  always_comb begin
    s1_m_d   = s1_m_q;
    s1_e_d   = s1_e_q;
    s1_ss_d  = s1_ss_q;
    s1_rm_d  = s1_rm_q;
    s1_spc_d = s1_spc_q;
    s1_nan_d = s1_nan_q;
    s2_res_d = s2_res_q;
    s2_flg_d = s2_flg_q;
    s2_ss_d  = s2_ss_q;
    s2_spc_d = s2_spc_q;
    s2_nan_d = s2_nan_q;
    s3_res_d = s3_res_q;
    s3_flg_d = s3_flg_q;
    if (ld1) begin
      s1_m_d   = n1_m;
      s1_e_d   = n1_e;
      s1_ss_d  = ss;
      s1_rm_d  = RM;
      s1_spc_d = {nans, inv, infs, zero};
      s1_nan_d = nan[50:0];
    end
    if (ld2) begin
      s2_res_d = rnd_res;
      s2_flg_d = {rnd_ovf, rnd_unf, rnd_inx};
      s2_ss_d  = s1_ss_q;
      s2_spc_d = s1_spc_q;
      s2_nan_d = s1_nan_q;
    end
    if (ld3) begin
      s3_res_d = pk_res;
      s3_flg_d = pk_flg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      s1_m_q   <= '0;
      s1_e_q   <= '0;
      s1_ss_q  <= 1'b0;
      s1_rm_q  <= '0;
      s1_spc_q <= '0;
      s1_nan_q <= '0;
      s2_res_q <= '0;
      s2_flg_q <= '0;
      s2_ss_q  <= 1'b0;
      s2_spc_q <= '0;
      s2_nan_q <= '0;
      s3_res_q <= '0;
      s3_flg_q <= '0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      s1_m_q   <= s1_m_d;
      s1_e_q   <= s1_e_d;
      s1_ss_q  <= s1_ss_d;
      s1_rm_q  <= s1_rm_d;
      s1_spc_q <= s1_spc_d;
      s1_nan_q <= s1_nan_d;
      s2_res_q <= s2_res_d;
      s2_flg_q <= s2_flg_d;
      s2_ss_q  <= s2_ss_d;
      s2_spc_q <= s2_spc_d;
      s2_nan_q <= s2_nan_d;
      s3_res_q <= s3_res_d;
      s3_flg_q <= s3_flg_d;
    end
  end

  assign out_valid = v3_q;
  assign result    = s3_res_q;
  assign fl_ovf    = s3_flg_q[3];
  assign fl_unf    = s3_flg_q[2];
  assign fl_inx    = s3_flg_q[1];
  assign fl_inv    = s3_flg_q[0];

endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: directed cases, backpressure, reset mid-flight and random beats
// scored against an arithmetic model of normalize/round/pack.
module tb_fp_round_pack;

  typedef struct packed {
    logic [10:0] es;
    logic [56:0] fs;
    logic        ss;
    logic        zero;
    logic        inv;
    logic        infs;
    logic        nans;
    logic [52:0] nan;
    logic [1:0]  rm;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [10:0] es;
  logic [56:0] fs;
  logic        ss, zero, inv, infs, nans;
  logic [52:0] nan;
  logic [1:0]  rm;
  logic        out_valid, out_ready;
  logic [63:0] result;
  logic        fl_ovf, fl_unf, fl_inx, fl_inv;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [67:0] exp_q[$];
  logic        bp_mode = 1'b0;

  fp_round_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .es(es), .fs(fs), .ss(ss), .zero(zero), .inv(inv), .infs(infs), .nans(nans),
    .nan(nan), .RM(rm), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .fl_ovf(fl_ovf), .fl_unf(fl_unf), .fl_inx(fl_inx), .fl_inv(fl_inv)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  // Reference: {result, ovf, unf, inx, inv} straight from the arithmetic rules.
  function automatic logic [67:0] model(input beat_t b);
    logic [57:0] sig;
    logic [53:0] keep;
    logic [2:0]  rem;
    logic        x, up, to_inf;
    int          e;
    if (b.nans) return {1'b0, 11'h7ff, 1'b1, b.nan[50:0], 4'b0000};
    if (b.inv)  return {64'h7ff8_0000_0000_0000, 4'b0001};
    if (b.infs) return {b.ss, 11'h7ff, 52'd0, 4'b0000};
    if (b.zero) return {b.ss, 63'd0, 4'b0000};
    e   = (b.es == 11'd0) ? 1 : int'(b.es);
    sig = {1'b0, b.fs};
    if (b.fs[56]) begin
      sig = (sig >> 1) | (sig & 58'd1);
      e++;
    end else if (b.fs != 57'd0) begin
      while (!sig[55] && e > 1) begin
        sig = sig << 1;
        e--;
      end
    end
    keep = {1'b0, sig[55:3]};
    rem  = sig[2:0];
    x    = (rem != 3'd0);
    case (b.rm)
      2'd0:    up = (rem > 3'd4) || (rem == 3'd4 && keep[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = x && !b.ss;
      default: up = x && b.ss;
    endcase
    keep = keep + 54'(up);
    if (keep[53]) begin
      keep = keep >> 1;
      e++;
    end
    if (e >= 2047) begin
      to_inf = (b.rm == 2'd0) || (b.rm == 2'd2 && !b.ss) || (b.rm == 2'd3 && b.ss);
      if (to_inf) return {b.ss, 11'h7ff, 52'd0, 4'b1010};
      return {b.ss, 11'h7fe, {52{1'b1}}, 4'b1010};
    end
    return {b.ss, keep[52] ? 11'(e) : 11'd0, keep[51:0], 1'b0, !sig[55] && x, x, 1'b0};
  endfunction

  function automatic beat_t mk(input logic [10:0] e, input logic [56:0] f,
                               input logic s, input logic [1:0] m);
    beat_t b;
    b    = '0;
    b.es = e;
    b.fs = f;
    b.ss = s;
    b.rm = m;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t       b;
    logic [63:0] r;
    int          mode;
    b    = '0;
    r    = {$urandom, $urandom};
    b.fs = r[56:0];
    b.es = 11'($urandom_range(0, 2047));
    b.ss = 1'($urandom_range(0, 1));
    b.rm = 2'($urandom_range(0, 3));
    mode = $urandom_range(0, 5);
    case (mode)
      1: b.fs = b.fs >> $urandom_range(1, 56);
      2: begin
        b.fs = b.fs >> $urandom_range(1, 56);
        b.es = 11'($urandom_range(0, 6));
      end
      3: b.es = 11'($urandom_range(2040, 2047));
      4: begin
        b.fs[56]  = 1'b0;
        b.fs[55]  = 1'b1;
        b.fs[2:0] = 3'b100;
      end
      5: begin
        r      = {$urandom, $urandom};
        b.nan  = r[52:0];
        b.nans = ($urandom_range(0, 3) == 0);
        b.inv  = ($urandom_range(0, 2) == 0);
        b.infs = ($urandom_range(0, 2) == 0);
        b.zero = ($urandom_range(0, 1) == 0);
        if ($urandom_range(0, 3) == 0) b.fs = 57'd0;
      end
      default: ;
    endcase
    return b;
  endfunction

  // driver tasks: called at a falling edge, return at a falling edge
  task automatic drive(input beat_t b);
    in_valid = 1'b1;
    es = b.es; fs = b.fs; ss = b.ss; rm = b.rm;
    zero = b.zero; inv = b.inv; infs = b.infs; nans = b.nans; nan = b.nan;
  endtask

  task automatic send(input beat_t b, input logic [67:0] exp);
    int guard;
    guard = 0;
    drive(b);
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      check("send_timeout", 68'(in_ready), 68'd1);
    end else begin
      exp_q.push_back(exp);
    end
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input beat_t b, input logic [67:0] exp);
    int cyc;
    send(b, exp);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 68'(cyc), 68'd3);
    @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 68'(exp_q.size()), 68'd0);
  endtask

  // scoreboard: sampled one time unit before each rising edge
  always begin
    @(negedge clk);
    #4;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 68'(out_valid), 68'd0);
      end else begin
        check("result", {result, fl_ovf, fl_unf, fl_inx, fl_inv}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (bp_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    beat_t b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    es = '0; fs = '0; ss = 1'b0; rm = '0;
    zero = 1'b0; inv = 1'b0; infs = 1'b0; nans = 1'b0; nan = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 68'(out_valid), 68'd0);
    check("rst_outputs", {result, fl_ovf, fl_unf, fl_inx, fl_inv}, 68'd0);
    check("rst_in_ready", 68'(in_ready), 68'd1);
    @(negedge clk);

    directed("norm_right", mk(11'h3ff, 57'd1 << 56, 1'b0, 2'd0), {64'h4000_0000_0000_0000, 4'b0000});
    directed("norm_left", mk(11'h3ff, 57'd1 << 53, 1'b0, 2'd0), {64'h3fd0_0000_0000_0000, 4'b0000});
    directed("norm_denorm", mk(11'h002, 57'd1 << 53, 1'b0, 2'd0), {64'h0008_0000_0000_0000, 4'b0000});
    directed("tie_rne", mk(11'h3ff, (57'd1 << 55) | 57'd4, 1'b0, 2'd0), {64'h3ff0_0000_0000_0000, 4'b0010});
    directed("tie_ru", mk(11'h3ff, (57'd1 << 55) | 57'd4, 1'b0, 2'd2), {64'h3ff0_0000_0000_0001, 4'b0010});
    directed("tie_rd", mk(11'h3ff, (57'd1 << 55) | 57'd4, 1'b1, 2'd3), {64'hbff0_0000_0000_0001, 4'b0010});
    directed("ovf_rne", mk(11'h7fe, 57'd1 << 56, 1'b0, 2'd0), {64'h7ff0_0000_0000_0000, 4'b1010});
    directed("ovf_rz", mk(11'h7fe, 57'd1 << 56, 1'b0, 2'd1), {64'h7fef_ffff_ffff_ffff, 4'b1010});
    b = mk(11'h0, 57'd0, 1'b0, 2'd0);
    b.nans = 1'b1;
    b.nan  = 53'h1;
    directed("spc_nan", b, {64'h7ff8_0000_0000_0001, 4'b0000});
    b = mk(11'h0, 57'd0, 1'b0, 2'd0);
    b.inv = 1'b1;
    directed("spc_inv", b, {64'h7ff8_0000_0000_0000, 4'b0001});
    b = mk(11'h0, 57'd0, 1'b1, 2'd0);
    b.infs = 1'b1;
    directed("spc_inf", b, {64'hfff0_0000_0000_0000, 4'b0000});
    directed("zero_sig", mk(11'h123, 57'd0, 1'b1, 2'd2), {64'h8000_0000_0000_0000, 4'b0000});

    // backpressure: three beats fill the pipe, the fourth must wait
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b = rnd_beat();
      send(b, model(b));
    end
    b = rnd_beat();
    drive(b);
    #1;
    check("bp_in_ready_low", 68'(in_ready), 68'd0);
    check("bp_out_valid", 68'(out_valid), 68'd1);
    @(negedge clk);
    out_ready = 1'b1;
    send(b, model(b));
    for (int i = 0; i < 2; i++) begin
      b = rnd_beat();
      send(b, model(b));
    end
    in_valid = 1'b0;
    drain();

    // random traffic with random backpressure
    bp_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      b = rnd_beat();
      send(b, model(b));
      if ($urandom_range(0, 5) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    drain();
    bp_mode   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // reset with two beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b = rnd_beat();
      send(b, model(b));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 68'(out_valid), 68'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 68'(out_valid), 68'd0);
    check("rst_mid_outputs", {result, fl_ovf, fl_unf, fl_inx, fl_inv}, 68'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 68'(in_ready), 68'd1);
    repeat (10) @(negedge clk);
    check("post_rst_idle", 68'(out_valid), 68'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
